// File: rtl/cu.sv
// rtl/cu.sv - Beta control unit: combinational decode plus a one-bit interrupt mask.
module cu (
    input  logic        clk,
    input  logic        RESET,
    input  logic        IRQ,
    input  logic        Z,
    input  logic [31:0] instruction,
    output logic [5:0]  ALUFN,
    output logic        ASEL,
    output logic        BSEL,
    output logic        MOE,
    output logic        MWR,
    output logic [2:0]  PCSEL,
    output logic        RA2SEL,
    output logic        WASEL,
    output logic [1:0]  WDSEL,
    output logic        WERF
);

    logic       irq_mask_q = 1'b0;
    logic       irq_mask_d;
    logic       irq_take;
    logic [5:0] opcode;

    assign opcode   = instruction[31:26];
    assign irq_take = IRQ & ~irq_mask_q;

    always_ff @(posedge clk) begin
        if (RESET) irq_mask_q <= 1'b0;
        else       irq_mask_q <= irq_mask_d;
    end

    always_comb begin
        ALUFN      = 'x;
        ASEL       = 1'bx;
        BSEL       = 1'bx;
        MOE        = 1'bx;
        MWR        = 1'b0;
        PCSEL      = 'x;
        RA2SEL     = 1'bx;
        WASEL      = 1'bx;
        WDSEL      = 'x;
        WERF       = 1'bx;
        irq_mask_d = irq_mask_q;
        if (RESET) begin
            irq_mask_d = 1'b0;
        end else if (irq_take) begin
            PCSEL      = 3'b100;
            WASEL      = 1'b1;
            WDSEL      = 2'b00;
            WERF       = 1'b1;
            irq_mask_d = 1'b1;
        end else begin
            casez (opcode)
                6'b10????: begin
                    ALUFN = opcode; ASEL = 1'b0; BSEL = 1'b0; PCSEL = 3'b000;
                    RA2SEL = 1'b0; WASEL = 1'b0; WDSEL = 2'b01; WERF = 1'b1;
                end
                6'b11????: begin
                    ALUFN = opcode; ASEL = 1'b0; BSEL = 1'b1; PCSEL = 3'b000;
                    WASEL = 1'b0; WDSEL = 2'b01; WERF = 1'b1;
                end
                6'b011000: begin
                    ALUFN = 6'b100000; ASEL = 1'b0; BSEL = 1'b1; MOE = 1'b1;
                    PCSEL = 3'b000; WASEL = 1'b0; WDSEL = 2'b10; WERF = 1'b1;
                end
                6'b011001: begin
                    ALUFN = 6'b100000; ASEL = 1'b0; BSEL = 1'b1; MOE = 1'b0;
                    MWR = 1'b1; PCSEL = 3'b000; RA2SEL = 1'b1; WERF = 1'b0;
                end
                6'b011011: begin
                    PCSEL = 3'b010; WASEL = 1'b0; WDSEL = 2'b00; WERF = 1'b1;
                    irq_mask_d = 1'b0;
                end
                6'b011100: begin
                    PCSEL = Z ? 3'b001 : 3'b000;
                    WASEL = 1'b0; WDSEL = 2'b00; WERF = 1'b1;
                end
                6'b011101: begin
                    PCSEL = Z ? 3'b000 : 3'b001;
                    WASEL = 1'b0; WDSEL = 2'b00; WERF = 1'b1;
                end
                6'b011111: begin
                    // LDR: ALU passes the PC-relative address straight through
                    ALUFN = 6'b111111; ASEL = 1'b1; MOE = 1'b1; PCSEL = 3'b000;
                    WASEL = 1'b0; WDSEL = 2'b10; WERF = 1'b1;
                end
                default: begin
                    PCSEL = 3'b011; WASEL = 1'b1; WDSEL = 2'b00; WERF = 1'b1;
                    irq_mask_d = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu.sv
// tb/tb_cu.sv - directed self-checking bench for cu.
module tb_cu;

    logic        clk = 1'b0;
    logic        RESET, IRQ, Z;
    logic [31:0] instruction;
    logic [5:0]  ALUFN;
    logic        ASEL, BSEL, MOE, MWR, RA2SEL, WASEL, WERF;
    logic [2:0]  PCSEL;
    logic [1:0]  WDSEL;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed view: ALUFN[17:12] ASEL[11] BSEL[10] MOE[9] MWR[8] PCSEL[7:5] RA2SEL[4] WASEL[3] WDSEL[2:1] WERF[0]
    localparam logic [17:0] C_ALUFN  = 18'h3F000;
    localparam logic [17:0] C_ASEL   = 18'h00800;
    localparam logic [17:0] C_BSEL   = 18'h00400;
    localparam logic [17:0] C_MOE    = 18'h00200;
    localparam logic [17:0] C_MWR    = 18'h00100;
    localparam logic [17:0] C_PCSEL  = 18'h000E0;
    localparam logic [17:0] C_RA2SEL = 18'h00010;
    localparam logic [17:0] C_WASEL  = 18'h00008;
    localparam logic [17:0] C_WDSEL  = 18'h00006;
    localparam logic [17:0] C_WERF   = 18'h00001;
    localparam logic [17:0] C_IRQROW = C_MWR | C_PCSEL | C_WASEL | C_WDSEL | C_WERF;
    localparam logic [17:0] C_BRROW  = C_MWR | C_PCSEL | C_WASEL | C_WDSEL | C_WERF;

    logic [17:0] obs;
    assign obs = {ALUFN, ASEL, BSEL, MOE, MWR, PCSEL, RA2SEL, WASEL, WDSEL, WERF};

    cu dut (
        .clk(clk), .RESET(RESET), .IRQ(IRQ), .Z(Z), .instruction(instruction),
        .ALUFN(ALUFN), .ASEL(ASEL), .BSEL(BSEL), .MOE(MOE), .MWR(MWR),
        .PCSEL(PCSEL), .RA2SEL(RA2SEL), .WASEL(WASEL), .WDSEL(WDSEL), .WERF(WERF)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic irq, input logic z, input logic [5:0] op);
        @(negedge clk);
        RESET       = rst;
        IRQ         = irq;
        Z           = z;
        instruction = {op, 26'h2A5_5A5A};
        #1;
    endtask

    task automatic check(input string tag, input logic [17:0] exp, input logic [17:0] care);
        n_checks++;
        assert (((obs ^ exp) & care) === 18'h0)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b care %b", tag, obs, exp, care);
        end
    endtask

    initial begin
        RESET = 1'b1; IRQ = 1'b0; Z = 1'b0; instruction = 32'h0;

        step(1, 1, 0, 6'b011001);
        check("reset_st_irq", 18'h0, C_MWR);
        step(1, 0, 1, 6'b100000);
        check("reset_op", 18'h0, C_MWR);

        step(0, 0, 0, 6'b100000);
        check("op_add", {6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1},
              ~C_MOE);
        step(0, 0, 0, 6'b110101);
        check("opc", {6'b110101, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1},
              ~(C_MOE | C_RA2SEL));
        step(0, 0, 0, 6'b011000);
        check("ld", {6'b100000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 1'b1},
              ~C_RA2SEL);
        step(0, 0, 0, 6'b011001);
        check("st", {6'b100000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0},
              ~(C_WASEL | C_WDSEL));
        step(0, 0, 1, 6'b011100);
        check("beq_z1", {12'h0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b1}, C_BRROW);
        step(0, 0, 0, 6'b011100);
        check("beq_z0", {12'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1}, C_BRROW);
        step(0, 0, 1, 6'b011101);
        check("bne_z1", {12'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1}, C_BRROW);
        step(0, 0, 0, 6'b011101);
        check("bne_z0", {12'h0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b1}, C_BRROW);
        step(0, 0, 0, 6'b011011);
        check("jmp", {12'h0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1}, C_BRROW);
        step(0, 0, 0, 6'b011111);
        check("ldr", {6'b111111, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b10, 1'b1},
              ~(C_BSEL | C_RA2SEL));
        step(0, 0, 0, 6'b011010);
        check("illop_011010", {12'h0, 3'b011, 1'b0, 1'b1, 2'b00, 1'b1}, C_IRQROW);
        step(0, 0, 0, 6'b011011);
        check("jmp_clear", {12'h0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1}, C_BRROW);

        // mask is 0 here: IRQ during ST is taken and suppresses the write
        step(0, 1, 0, 6'b011001);
        check("irq_st", {12'h0, 3'b100, 1'b0, 1'b1, 2'b00, 1'b1}, C_IRQROW);
        step(0, 0, 0, 6'b000000);
        check("illop_000000", {12'h0, 3'b011, 1'b0, 1'b1, 2'b00, 1'b1}, C_IRQROW);
        step(0, 1, 0, 6'b011001);
        check("irq_masked_st", {6'b100000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0},
              ~(C_WASEL | C_WDSEL));
        step(0, 1, 0, 6'b011011);
        check("irq_masked_jmp", {12'h0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1}, C_BRROW);
        step(0, 1, 0, 6'b011001);
        check("irq_after_jmp", {12'h0, 3'b100, 1'b0, 1'b1, 2'b00, 1'b1}, C_IRQROW);
        step(0, 0, 0, 6'b011011);
        check("jmp_ret", {12'h0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1}, C_BRROW);
        step(0, 1, 0, 6'b000000);
        check("irq_beats_illop", {12'h0, 3'b100, 1'b0, 1'b1, 2'b00, 1'b1}, C_IRQROW);
        step(0, 1, 0, 6'b100000);
        check("irq_masked_op", {6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1},
              ~C_MOE);

        // reset mid-handler clears the mask
        step(1, 1, 0, 6'b011001);
        check("reset_mid_handler", 18'h0, C_MWR);
        step(0, 1, 0, 6'b011001);
        check("irq_after_reset", {12'h0, 3'b100, 1'b0, 1'b1, 2'b00, 1'b1}, C_IRQROW);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
